// File: rtl/velocity_cell_dbuf_if.sv
// Bus bundle for velocity_cell_dbuf: read port, write port, swap handshake and
// the particle-count mirrors. The slave modport is the memory side.
interface velocity_cell_dbuf_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8
);
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  swap_req;
  logic                  swap_ack;
  logic                  active_bank;
  logic [ADDR_WIDTH-1:0] rd_particle_num;
  logic [ADDR_WIDTH-1:0] wr_particle_num;
  logic                  addr_err;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, swap_req,
    input  rd_data, rd_valid, swap_ack, active_bank,
           rd_particle_num, wr_particle_num, addr_err
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, swap_req,
    output rd_data, rd_valid, swap_ack, active_bank,
           rd_particle_num, wr_particle_num, addr_err
  );
endinterface

// File: rtl/velocity_cell_dbuf.sv
// Double-buffered per-cell velocity memory. Readers see the active bank while
// the motion-update stage fills the shadow bank; a swap handshake exchanges
// them between iterations. Address 0 of each bank is the particle count and is
// mirrored in rd_particle_num / wr_particle_num.
// Optional: define VELOCITY_ADDR_CHECK_EN to reject addresses >= PARTICLE_NUM
// and report them on addr_err; otherwise addr_err is tied low.
//
// state   | meaning
// IDLE    | no swap outstanding
// PENDING | swap requested during a write; waits for a write-free cycle
// ACK     | swap executed on the previous edge; swap_ack high
module velocity_cell_dbuf #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic               clk,
  input  logic               rst,
  velocity_cell_dbuf_if.slave vel_if
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  logic [DATA_WIDTH-1:0] bank0_q [PARTICLE_NUM];
  logic [DATA_WIDTH-1:0] bank1_q [PARTICLE_NUM];

  logic [1:0]            state_q, state_d;
  logic                  req_lat_q, req_lat_d;
  logic                  do_swap;
  logic                  active_bank_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic [ADDR_WIDTH-1:0] rd_num_q;
  logic [ADDR_WIDTH-1:0] wr_num_q;
  logic                  rd_in_range;
  logic                  wr_in_range;
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] rd_word;

`ifdef VELOCITY_ADDR_CHECK_EN
  logic addr_err_q;

  assign rd_in_range = 32'(vel_if.rd_addr) < 32'(PARTICLE_NUM);
  assign wr_in_range = 32'(vel_if.wr_addr) < 32'(PARTICLE_NUM);

  // One-cycle error pulse, aligned with a read result or the cycle after a write
  always_ff @(posedge clk) begin
    if (!rst) addr_err_q <= 1'b0;
    else      addr_err_q <= (vel_if.rd_en && !rd_in_range) ||
                            (vel_if.wr_en && !wr_in_range);
  end

  assign vel_if.addr_err = addr_err_q;
`else
  assign rd_in_range     = 1'b1;
  assign wr_in_range     = 1'b1;
  assign vel_if.addr_err = 1'b0;
`endif

  // Writes are held off while reset is asserted so the arrays keep their contents
  assign wr_ok   = rst && vel_if.wr_en && wr_in_range;
  assign rd_word = active_bank_q ? bank1_q[vel_if.rd_addr] : bank0_q[vel_if.rd_addr];

  // Shadow-bank writes; bank 0 is the shadow when bank 1 is active
  always_ff @(posedge clk) begin
    if (wr_ok && active_bank_q) bank0_q[vel_if.wr_addr] <= vel_if.wr_data;
  end

  // Shadow-bank writes; bank 1 is the shadow when bank 0 is active
  always_ff @(posedge clk) begin
    if (wr_ok && !active_bank_q) bank1_q[vel_if.wr_addr] <= vel_if.wr_data;
  end

  // Registered read of the active bank; data holds when no read is issued
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= vel_if.rd_en;
      if (vel_if.rd_en) rd_data_q <= rd_in_range ? rd_word : '0;
    end
  end

  // Swap sequencing: a swap never shares an edge with a write
  always_comb begin
    state_d   = state_q;
    req_lat_d = req_lat_q;
    do_swap   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (vel_if.swap_req || req_lat_q) begin
          req_lat_d = 1'b0;
          if (vel_if.wr_en) begin
            state_d = ST_PEND;
          end else begin
            do_swap = 1'b1;
            state_d = ST_ACK;
          end
        end
      end
      ST_PEND: begin
        if (!vel_if.wr_en) begin
          do_swap = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        if (vel_if.swap_req) req_lat_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and the request seen during ACK
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      req_lat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_lat_q <= req_lat_d;
    end
  end

  // Bank select and particle-count mirrors
  always_ff @(posedge clk) begin
    if (!rst) begin
      active_bank_q <= 1'b0;
      rd_num_q      <= '0;
      wr_num_q      <= '0;
    end else if (do_swap) begin
      active_bank_q <= ~active_bank_q;
      rd_num_q      <= wr_num_q;
      wr_num_q      <= '0;
    end else if (wr_ok && vel_if.wr_addr == '0) begin
      wr_num_q      <= vel_if.wr_data[ADDR_WIDTH-1:0];
    end
  end

  assign vel_if.rd_data         = rd_data_q;
  assign vel_if.rd_valid        = rd_valid_q;
  assign vel_if.swap_ack        = (state_q == ST_ACK);
  assign vel_if.active_bank     = active_bank_q;
  assign vel_if.rd_particle_num = rd_num_q;
  assign vel_if.wr_particle_num = wr_num_q;

endmodule

// File: tb/tb_velocity_cell_dbuf.sv
// Bench for velocity_cell_dbuf: directed scenarios followed by random traffic,
// every cycle compared against a bank-array reference model.
module tb_velocity_cell_dbuf;
  localparam int DW = 96;
  localparam int PN = 220;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  velocity_cell_dbuf_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) vif ();

  velocity_cell_dbuf #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .vel_if (vif.slave)
  );

  // reference model state
  logic [DW-1:0] mbank  [2][PN];
  bit            mknown [2][PN];
  bit            m_act, m_rdv, m_rdk, m_pend, m_ack, m_err;
  logic [DW-1:0] m_rdd;
  logic [AW-1:0] m_rdn, m_wrn;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
  endtask

  task automatic check_all();
    chk("rd_valid", DW'(vif.rd_valid), DW'(m_rdv));
    if (m_rdk) chk("rd_data", vif.rd_data, m_rdd);
    chk("swap_ack", DW'(vif.swap_ack), DW'(m_ack));
    chk("active_bank", DW'(vif.active_bank), DW'(m_act));
    chk("rd_particle_num", DW'(vif.rd_particle_num), DW'(m_rdn));
    chk("wr_particle_num", DW'(vif.wr_particle_num), DW'(m_wrn));
    chk("addr_err", DW'(vif.addr_err), DW'(m_err));
  endtask

  // one clock: sample inputs, advance model across the edge, compare after it
  task automatic step();
    bit            re, we, sr, rs, rd_oor, wr_oor;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wd;
    re = vif.rd_en; ra = vif.rd_addr;
    we = vif.wr_en; wa = vif.wr_addr; wd = vif.wr_data;
    sr = vif.swap_req; rs = rst;
    rd_oor = 1'b0; wr_oor = 1'b0;
`ifdef VELOCITY_ADDR_CHECK_EN
    rd_oor = int'(ra) >= PN;
    wr_oor = int'(wa) >= PN;
`endif
    @(posedge clk);
    if (!rs) begin
      m_act = 0; m_rdv = 0; m_rdd = '0; m_rdk = 1; m_rdn = '0; m_wrn = '0;
      m_pend = 0; m_ack = 0; m_err = 0;
    end else begin
      m_err = (re && rd_oor) || (we && wr_oor);
      m_rdv = re;
      if (re) begin
        if (rd_oor) begin
          m_rdd = '0; m_rdk = 1;
        end else begin
          m_rdd = mbank[m_act][ra]; m_rdk = mknown[m_act][ra];
        end
      end
      if (we && !wr_oor) begin
        mbank[!m_act][wa]  = wd;
        mknown[!m_act][wa] = 1;
        if (wa == 0) m_wrn = wd[AW-1:0];
      end
      if (m_ack) begin
        m_ack = 0;
        if (sr) m_pend = 1;
      end else if ((m_pend || sr) && !we) begin
        m_act = !m_act; m_rdn = m_wrn; m_wrn = '0; m_pend = 0; m_ack = 1;
      end else if (sr) begin
        m_pend = 1;
      end
    end
    #1;
    check_all();
  endtask

  task automatic idle();
    vif.rd_en = 0; vif.wr_en = 0; vif.swap_req = 0;
  endtask

  function automatic logic [DW-1:0] vec(input int z, input int y, input int x);
    return {z[31:0], y[31:0], x[31:0]};
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    int lat;
    vif.rd_addr = '0; vif.wr_addr = '0; vif.wr_data = '0;
    idle();
    m_act = 0; m_rdv = 0; m_rdd = '0; m_rdk = 1; m_rdn = '0; m_wrn = '0;
    m_pend = 0; m_ack = 0; m_err = 0;

    // reset
    rst = 0; step(); step();
    rst = 1;

    // count + one word, swap, read back
    vif.wr_en = 1; vif.wr_addr = 0; vif.wr_data = vec(0, 0, 5); step();
    vif.wr_addr = 1; vif.wr_data = vec(3, 2, 1); step();
    vif.wr_en = 0; vif.swap_req = 1; step();
    chk("t1_ack", DW'(vif.swap_ack), DW'(1));
    vif.swap_req = 0; vif.rd_en = 1; vif.rd_addr = 1; step();
    chk("t1_rd_data", vif.rd_data, vec(3, 2, 1));
    chk("t1_rd_num", DW'(vif.rd_particle_num), DW'(5));
    chk("t1_active", DW'(vif.active_bank), DW'(1));
    chk("t1_wr_num", DW'(vif.wr_particle_num), DW'(0));

    // same-address read and write are independent
    vif.rd_addr = 1; vif.wr_en = 1; vif.wr_addr = 1; vif.wr_data = vec(9, 9, 9); step();
    chk("t2_old_data", vif.rd_data, vec(3, 2, 1));
    vif.rd_en = 0; vif.wr_en = 0; vif.swap_req = 1; step();
    vif.swap_req = 0; vif.rd_en = 1; step();
    chk("t2_new_data", vif.rd_data, vec(9, 9, 9));

    // swap requested at the start of a 3-cycle write burst
    idle();
    vif.swap_req = 1; vif.wr_en = 1; vif.wr_addr = 10; vif.wr_data = vec(10, 11, 12); step();
    lat = 1;
    vif.swap_req = 0; vif.wr_addr = 11; vif.wr_data = vec(20, 21, 22); step(); lat++;
    vif.wr_addr = 12; vif.wr_data = vec(30, 31, 32); step(); lat++;
    vif.wr_en = 0;
    while (!vif.swap_ack && lat < 10) begin
      step(); lat++;
    end
    chk("t3_ack_latency", DW'(lat), DW'(4));
    vif.rd_en = 1; vif.rd_addr = 10; step();
    chk("t3_rd10", vif.rd_data, vec(10, 11, 12));
    vif.rd_addr = 11; step();
    chk("t3_rd11", vif.rd_data, vec(20, 21, 22));
    vif.rd_addr = 12; step();
    chk("t3_rd12", vif.rd_data, vec(30, 31, 32));

    // read in the swap cycle and in the one after
    idle();
    vif.wr_en = 1; vif.wr_addr = 10; vif.wr_data = vec(44, 45, 46); step();
    vif.wr_en = 0; vif.rd_en = 1; vif.rd_addr = 10; vif.swap_req = 1; step();
    chk("t4_old_bank", vif.rd_data, vec(10, 11, 12));
    vif.swap_req = 0; step();
    chk("t4_new_bank", vif.rd_data, vec(44, 45, 46));

    // get bank 1 active, then reset while a swap is pending and a read in flight
    idle(); vif.swap_req = 1; step(); vif.swap_req = 0; step();
    vif.swap_req = 1; vif.wr_en = 1; vif.wr_addr = 20; vif.wr_data = rnd_word(); step();
    vif.swap_req = 0; vif.rd_en = 1; vif.rd_addr = 10; rst = 0; step();
    chk("t5_rd_valid", DW'(vif.rd_valid), DW'(0));
    chk("t5_active", DW'(vif.active_bank), DW'(0));
    rst = 1; idle();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_no_ack", DW'(vif.swap_ack), DW'(0));
    end

`ifdef VELOCITY_ADDR_CHECK_EN
    // out-of-range write then read
    vif.wr_en = 1; vif.wr_addr = 8'd230; vif.wr_data = rnd_word(); step();
    chk("t6_wr_err", DW'(vif.addr_err), DW'(1));
    vif.wr_en = 0; vif.rd_en = 1; vif.rd_addr = 8'd230; step();
    chk("t6_rd_err", DW'(vif.addr_err), DW'(1));
    chk("t6_rd_valid", DW'(vif.rd_valid), DW'(1));
    chk("t6_rd_zero", vif.rd_data, '0);
    chk("t6_wr_num", DW'(vif.wr_particle_num), DW'(0));
    idle(); step();
    chk("t6_err_clear", DW'(vif.addr_err), DW'(0));
`endif

    // fill both banks so random reads hit known data
    idle();
    for (int b = 0; b < 2; b++) begin
      vif.wr_en = 1;
      for (int a = 0; a < PN; a++) begin
        vif.wr_addr = AW'(a); vif.wr_data = rnd_word(); step();
      end
      vif.wr_en = 0; vif.swap_req = 1; step();
      vif.swap_req = 0; step();
    end

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      vif.rd_en    = ($urandom_range(3, 0) != 0);
      vif.rd_addr  = AW'($urandom_range(PN - 1, 0));
      vif.wr_en    = ($urandom_range(1, 0) != 0);
      vif.wr_addr  = ($urandom_range(7, 0) == 0) ? '0 : AW'($urandom_range(PN - 1, 0));
      vif.wr_data  = rnd_word();
      vif.swap_req = ($urandom_range(7, 0) == 0);
      rst          = ($urandom_range(299, 0) != 0);
      step();
    end
    rst = 1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/velocity_cell_dbuf.md
# velocity_cell_dbuf

Double-buffered, parametrised per-cell velocity memory for the range-limited MD pipeline. It holds two banks of `{vz, vy, vx}` words per cell. The motion-update stage reads the current iteration's velocities from the active bank while the updated velocities are written into the shadow bank. A swap handshake exchanges the banks between iterations. Address 0 of each bank holds the cell's particle count, and that count is mirrored in registers so the cell cache does not spend a read cycle on it.

## Interface
- `DATA_WIDTH`, 96: word width, `{vz, vy, vx}`, 32 bits each.
- `PARTICLE_NUM`, 220: words per bank, including the count word at address 0.
- `ADDR_WIDTH`, 8: address width; must satisfy 2^ADDR_WIDTH >= PARTICLE_NUM.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `rd_en` in 1: read request to the active bank.
- `rd_addr` in ADDR_WIDTH: read address.
- `rd_data` out DATA_WIDTH: registered read data.
- `rd_valid` out 1: `rd_data` is valid this cycle.
- `wr_en` in 1: write request to the shadow bank.
- `wr_addr` in ADDR_WIDTH: write address.
- `wr_data` in DATA_WIDTH: write data.
- `swap_req` in 1: request a bank exchange (pulse or level).
- `swap_ack` out 1: one-cycle pulse, swap completed.
- `active_bank` out 1: index of the bank currently served to readers.
- `rd_particle_num` out ADDR_WIDTH: particle count of the active bank.
- `wr_particle_num` out ADDR_WIDTH: particle count written so far to the shadow bank.
- `addr_err` out 1: one-cycle pulse on an out-of-range access (see Configuration).

## Operation
**Banks**
- Two arrays of PARTICLE_NUM x DATA_WIDTH, inferred as M20K.
- Reads always target bank `active_bank`; writes always target bank `~active_bank`.
- Because a read and a write never share a bank, simultaneous accesses to the same address are independent.

**Read**
- When `rd_en`=1, the word at `rd_addr` appears on `rd_data` with `rd_valid`=1 on the next cycle.
- When `rd_en`=0, `rd_valid`=0 next cycle and `rd_data` holds its last value.

**Write**
- When `wr_en`=1, `wr_data` is stored at `wr_addr` on the edge.
- A write to address 0 also loads `wr_particle_num <= wr_data[ADDR_WIDTH-1:0]`.

**Swap FSM**
- IDLE:
  - `swap_req`=1 and `wr_en`=0 -> execute the swap on this edge, go to ACK.
  - `swap_req`=1 and `wr_en`=1 -> go to PENDING; the write completes into the old shadow bank.
- PENDING: wait for the first cycle with `wr_en`=0, then execute the swap and go to ACK. `swap_req` is not required to remain high.
- ACK: `swap_ack`=1 for this one cycle, then go to IDLE. A `swap_req` seen in ACK is latched and serviced from IDLE.
- Executing a swap does three things on the same edge:
  - `active_bank <= ~active_bank`
  - `rd_particle_num <= wr_particle_num`
  - `wr_particle_num <= 0`
- Reads and swaps may overlap:
  - A read issued in the swap cycle returns data from the old bank.
  - A read issued in the next cycle returns data from the new bank.

**Reset** (`rst`=0 at an edge)
- Outputs: `active_bank`=0, `rd_data`=0, `rd_valid`=0, `rd_particle_num`=0, `wr_particle_num`=0, `swap_ack`=0, `addr_err`=0.
- FSM returns to IDLE; a pending swap is dropped and a read in flight produces no `rd_valid`.
- Array contents are not cleared.

## Timing
- Read latency is exactly 1 cycle; throughput is 1 read and 1 write per cycle, sustained.
- Written data becomes readable after a swap: the earliest read to return it is issued the cycle after the swap edge.
- Swap latency from `swap_req` to `swap_ack`:
  - 1 cycle when no write is active.
  - N+1 cycles when N back-to-back write cycles start in the request cycle.
- Count registers update on the same edge as the triggering write or swap.

## Configuration
- `VELOCITY_ADDR_CHECK_EN` defined:
  - An access with address >= PARTICLE_NUM is rejected: a write is suppressed and changes neither the array nor `wr_particle_num`.
  - A rejected read returns `rd_data`=0, still with `rd_valid`=1.
  - `addr_err` pulses for 1 cycle, aligned with the read result or the cycle after the write.
- Not defined: `addr_err` is tied to 0 and out-of-range behaviour is undefined; there is no comparator logic.

## Test plan
- Reset, then write 5 to address 0 and `{3,2,1}` to address 1, then swap, then read address 1 -> `rd_data`={3,2,1} one cycle later; `rd_particle_num`=5, `active_bank`=1, `wr_particle_num`=0.
- Read address 1 and write `{9,9,9}` to address 1 in the same cycle, both before a swap -> `rd_data` is the old active-bank value; `{9,9,9}` is returned only after the next swap.
- Raise `swap_req` during a 3-cycle write burst -> swap executes on the first idle-write cycle; `swap_ack` comes 4 cycles after the request; all 3 writes are visible after the swap.
- Read in the swap cycle and read in the following cycle -> the first returns old-bank data, the second new-bank data.
- Assert `rst`=0 while a swap is PENDING and a read is in flight -> no `swap_ack`, no `rd_valid`, `active_bank`=0.
- With `VELOCITY_ADDR_CHECK_EN`, write and read address 230 with PARTICLE_NUM=220 -> write ignored, `rd_data`=0 with `rd_valid`=1, `addr_err` pulsed twice.
